// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehaze pipeline control blocks.
//   state_e : frame sequencer states
//   tag_t   : per-pixel tag travelling alongside the transmission datapath
package dehaze_pkg;
  localparam int INVA_W    = 9;
  localparam int T_W       = 12;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_A = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  typedef struct packed {
    logic vld;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;
endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth delay line, async active-high reset.
//   din  : word entering this cycle
//   dout : word that entered DEPTH cycles earlier
module tag_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/transmission_ctrl.sv
// Frame sequencer for the transmission-estimation datapath.
//   a_valid/a_ready/a_inv* : invA triple from the atmospheric-light estimator
//   invA_*                 : frame-stable reciprocals to the datapath
//   win_valid/win_ready    : 3x3 window handshake from the line buffers
//   dp_en                  : window accepted, qualifies datapath inputs
//   t_valid/sof/eol/eof    : tags aligned to the datapath output
//   frame_done             : pulse the cycle after the last output of a frame
//   busy                   : controller out of IDLE
module transmission_ctrl
  import dehaze_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [INVA_W-1:0] a_invR,
  input  logic [INVA_W-1:0] a_invG,
  input  logic [INVA_W-1:0] a_invB,
  output logic [INVA_W-1:0] invA_R,
  output logic [INVA_W-1:0] invA_G,
  output logic [INVA_W-1:0] invA_B,
  input  logic              win_valid,
  output logic              win_ready,
  output logic              dp_en,
  output logic              t_valid,
  output logic              t_sof,
  output logic              t_eol,
  output logic              t_eof,
  output logic              frame_done,
  output logic              busy
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;
  logic [3*INVA_W-1:0]     inva_q, inva_d;
  logic [3*INVA_W-1:0]     shd_q, shd_d;
  logic                    pend_q, pend_d;
  logic                    fdone_q, fdone_d;
  logic [3*INVA_W-1:0]     a_in;
  logic                    a_hs, col_last, row_last, last_pix, drain_last;
  tag_t                    tag_in, tag_out;

  assign a_in = {a_invR, a_invG, a_invB};

  always_comb begin
    win_ready  = (state_q == S_RUN);
    dp_en      = win_valid && win_ready;
    // During a frame only one replacement triple can be parked at a time.
    a_ready    = (state_q == S_WAIT_A) ||
                 (((state_q == S_RUN) || (state_q == S_DRAIN)) && !pend_q);
    a_hs       = a_valid && a_ready;
    col_last   = (col_q == COL_LAST);
    row_last   = (row_q == ROW_LAST);
    last_pix   = dp_en && col_last && row_last;
    drain_last = (state_q == S_DRAIN) && (dcnt_q == DCNT_LAST);

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    inva_d  = inva_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    fdone_d = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_WAIT_A;
      S_WAIT_A: begin
        if (a_hs) begin
          inva_d  = a_in;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (a_hs) begin
          shd_d  = a_in;
          pend_d = 1'b1;
        end
        if (dp_en) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (last_pix) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          // The last tag leaves the pipe now, so invA may switch safely.
          fdone_d = 1'b1;
          if (pend_q) begin
            inva_d  = shd_q;
            pend_d  = 1'b0;
            state_d = S_RUN;
          end else if (a_hs) begin
            inva_d  = a_in;
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT_A;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
          if (a_hs) begin
            shd_d  = a_in;
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
      inva_q  <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      inva_q  <= inva_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    tag_in.vld = dp_en;
    tag_in.sof = dp_en && (row_q == '0) && (col_q == '0);
    tag_in.eol = dp_en && col_last;
    tag_in.eof = last_pix;
  end

  tag_delay_line #(.DEPTH(LATENCY), .WIDTH($bits(tag_t))) u_tags (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign t_valid    = tag_out.vld;
  assign t_sof      = tag_out.sof;
  assign t_eol      = tag_out.eol;
  assign t_eof      = tag_out.eof;
  assign frame_done = fdone_q;
  assign busy       = (state_q != S_IDLE);
  assign invA_R     = inva_q[3*INVA_W-1:2*INVA_W];
  assign invA_G     = inva_q[2*INVA_W-1:INVA_W];
  assign invA_B     = inva_q[INVA_W-1:0];
endmodule

// File: tb/tb_transmission_ctrl.sv
// Bench for transmission_ctrl with a 4x2 frame and 4-cycle datapath.
module tb_transmission_ctrl;
  localparam int W = 4, H = 2, L = 4, NPIX = W * H;

  logic       clk = 1'b0, rst = 1'b1;
  logic       a_valid = 1'b0, a_ready;
  logic [8:0] a_invR = '0, a_invG = '0, a_invB = '0;
  logic [8:0] invA_R, invA_G, invA_B;
  logic       win_valid = 1'b0, win_ready, dp_en;
  logic       t_valid, t_sof, t_eol, t_eof, frame_done, busy;

  transmission_ctrl #(.IMG_W(W), .IMG_H(H), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready),
    .a_invR(a_invR), .a_invG(a_invG), .a_invB(a_invB),
    .invA_R(invA_R), .invA_G(invA_G), .invA_B(invA_B),
    .win_valid(win_valid), .win_ready(win_ready), .dp_en(dp_en),
    .t_valid(t_valid), .t_sof(t_sof), .t_eol(t_eol), .t_eof(t_eof),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame position as a pixel index, drain as cycles remaining,
  // output tags as a queue of what entered the datapath L cycles ago.
  int          m_mode;   // 0 idle, 1 wait for invA, 2 run, 3 drain
  int          m_pix, m_drem;
  logic [26:0] m_inva, m_shd;
  bit          m_pend, m_fd;
  logic [3:0]  m_tq[$];

  always @(negedge clk) begin : model
    logic       e_ar, e_wr, e_dp, hs;
    logic [3:0] nt;
    logic [26:0] a_in;
    bit         fd_n;
    if (rst) begin
      m_mode = 0; m_pix = 0; m_drem = 0; m_inva = '0; m_shd = '0;
      m_pend = 0; m_fd = 0;
      m_tq = {};
      for (int i = 0; i < L; i++) m_tq.push_back(4'b0);
    end
    e_wr = (m_mode == 2);
    e_dp = win_valid && e_wr;
    e_ar = (m_mode == 1) || ((m_mode == 2 || m_mode == 3) && !m_pend);
    hs   = a_valid && e_ar;
    a_in = {a_invR, a_invG, a_invB};
    chk("a_ready", 32'(a_ready), 32'(e_ar));
    chk("win_ready", 32'(win_ready), 32'(e_wr));
    chk("dp_en", 32'(dp_en), 32'(e_dp));
    chk("tags", 32'({t_valid, t_sof, t_eol, t_eof}), 32'(m_tq[0]));
    chk("invA", 32'({invA_R, invA_G, invA_B}), 32'(m_inva));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    if (!rst) begin
      nt = {e_dp, e_dp && (m_pix == 0), e_dp && (m_pix % W == W - 1), e_dp && (m_pix == NPIX - 1)};
      m_tq.push_back(nt);
      void'(m_tq.pop_front());
      fd_n = 0;
      case (m_mode)
        0: m_mode = 1;
        1: if (hs) begin m_inva = a_in; m_mode = 2; m_pix = 0; end
        2: begin
          if (hs) begin m_shd = a_in; m_pend = 1; end
          if (e_dp) begin
            if (m_pix == NPIX - 1) begin m_mode = 3; m_drem = L; m_pix = 0; end
            else m_pix++;
          end
        end
        default: begin
          if (m_drem == 1) begin
            fd_n = 1;
            if (m_pend) begin m_inva = m_shd; m_pend = 0; m_mode = 2; end
            else if (hs) begin m_inva = a_in; m_mode = 2; end
            else m_mode = 1;
            m_pix = 0;
          end else begin
            if (hs) begin m_shd = a_in; m_pend = 1; end
            m_drem--;
          end
        end
      endcase
      m_fd = fd_n;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Holds a_valid until accepted; returns one cycle after the handshake edge.
  task automatic offer(input logic [8:0] r, g, b);
    bit ok;
    ok = 0;
    step();
    a_invR = r; a_invG = g; a_invB = b; a_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (a_ready) ok = 1;
      step();
    end
    a_valid = 1'b0;
    chk("offer_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_fd(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1;
    end
    chk("frame_done_seen", 32'(ok), 32'd1);
  endtask

  int   nv, nfd, first_tv, fd_cyc, sof_beat, eof_beat;
  logic [7:0] eol_mask;
  bit   dp_h[64], tv_h[64];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Frame with win_valid held high.
    win_valid = 1'b1;
    offer(9'h100, 9'h120, 9'h140);
    chk("t1_invA", 32'({invA_R, invA_G, invA_B}), 32'({9'h100, 9'h120, 9'h140}));
    nv = 0; nfd = 0; first_tv = -1; fd_cyc = -1; sof_beat = -1; eof_beat = -1; eol_mask = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_valid) begin
        if (first_tv < 0) first_tv = i;
        if (t_sof) sof_beat = nv;
        if (t_eof) eof_beat = nv;
        if (t_eol) eol_mask[nv[2:0]] = 1'b1;
        nv++;
      end
      if (frame_done) begin nfd++; fd_cyc = i; end
    end
    chk("t1_beats", 32'(nv), 32'd8);
    chk("t1_first_tv", 32'(first_tv), 32'd4);
    chk("t1_sof_beat", 32'(sof_beat), 32'd0);
    chk("t1_eol_beats", 32'(eol_mask), 32'h88);
    chk("t1_eof_beat", 32'(eof_beat), 32'd7);
    chk("t1_fd_cycle", 32'(fd_cyc), 32'd12);
    chk("t1_fd_count", 32'(nfd), 32'd1);

    // No new invA offered: controller waits, refusing windows.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_win_ready", 32'(win_ready), 32'd0);
      chk("t4_a_ready", 32'(a_ready), 32'd1);
    end

    // Bubbles: win_valid alternates 1/0 from the first RUN cycle.
    step();
    win_valid = 1'b0;
    offer(9'h011, 9'h012, 9'h013);
    fd_cyc = -1; nv = 0;
    for (int i = 0; i < 40 && fd_cyc < 0; i++) begin
      win_valid = (i % 2 == 0);
      @(negedge clk);
      dp_h[i] = dp_en; tv_h[i] = t_valid;
      if (t_valid) nv++;
      if (frame_done) fd_cyc = i;
      else step();
    end
    chk("t2_fd_cycle", 32'(fd_cyc), 32'd19);
    chk("t2_beats", 32'(nv), 32'd8);
    for (int j = L; j <= fd_cyc && j < 64; j++)
      chk("t2_tv_delay", 32'(tv_h[j]), 32'(dp_h[j-L]));

    // Mid-frame invA update, applied only at the end of drain.
    step();
    win_valid = 1'b1;
    offer(9'h050, 9'h051, 9'h052);
    step();
    offer(9'h0AA, 9'h0AB, 9'h0AC);
    chk("t3_invA_hold", 32'(invA_R), 32'h050);
    a_invR = 9'h0BB; a_valid = 1'b1;
    @(negedge clk);
    chk("t3_refuse", 32'(a_ready), 32'd0);
    step();
    a_valid = 1'b0;
    wait_fd(30);
    chk("t3_invA_new", 32'(invA_R), 32'h0AA);
    chk("t3_no_wait_a", 32'(win_ready), 32'd1);

    // Offer lands on the last pixel of the frame.
    repeat (7) step();
    a_invR = 9'h0CC; a_invG = 9'h0CD; a_invB = 9'h0CE; a_valid = 1'b1;
    @(negedge clk);
    chk("t6_last_pix", 32'({dp_en, a_ready}), 32'b11);
    step();
    a_valid = 1'b0;
    wait_fd(30);
    chk("t6_invA", 32'({invA_R, invA_G, invA_B}), 32'({9'h0CC, 9'h0CD, 9'h0CE}));
    chk("t6_run", 32'(win_ready), 32'd1);

    // Reset at row 1, col 2.
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({a_ready, win_ready, dp_en, t_valid, t_sof, t_eol, t_eof, frame_done, busy}), 32'd0);
    chk("t5_rst_invA", 32'({invA_R, invA_G, invA_B}), 32'd0);
    step();
    rst = 1'b0;
    nfd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (frame_done) nfd++;
    end
    chk("t5_no_fd", 32'(nfd), 32'd0);
    offer(9'h100, 9'h120, 9'h140);
    nv = 0;
    for (int i = 0; i < 20 && nv == 0; i++) begin
      @(negedge clk);
      if (t_valid) begin
        nv = 1;
        chk("t5_restart_sof", 32'(t_sof), 32'd1);
      end
    end
    chk("t5_restart_seen", 32'(nv), 32'd1);
    wait_fd(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
